// File: rtl/ptc_tap_ctrl.sv
// Tap-select controller for the PTC delay line.
// Filters phase-detector votes, steps a 4-bit tap index, and tracks lock
// from the pattern of direction reversals.
module ptc_tap_ctrl #(
  parameter int FILT_TH  = 4,
  parameter int LOCK_CNT = 8,
  parameter int INIT_Q   = 8,
  parameter int Q_MIN    = 1,
  parameter int Q_MAX    = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       pd_valid,
  input  logic       pd_up,
  input  logic       pd_dn,
  output logic [3:0] Q,
  output logic       step_up,
  output logic       step_dn,
  output logic       locked,
  output logic       sat
);

  localparam int unsigned AW = $clog2(FILT_TH) + 2;
  localparam int unsigned RW = 4;
  localparam logic signed [AW-1:0] TH_P = AW'(FILT_TH);
  localparam logic signed [AW-1:0] TH_N = AW'(-FILT_TH);

  typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DN} dir_t;
  typedef enum logic {ACQ, LOCKED} state_t;

  logic signed [AW-1:0] acc, acc_n, vote, acc_sum;
  logic [3:0]           q_n;
  logic [RW-1:0]        rev_cnt, rev_n;
  dir_t                 last_dir, last_n, dir;
  state_t               state, state_n;
  logic                 up_n, dn_n, sat_n;
  logic                 req_up, req_dn, can_step;

  // Vote filtering, step execution, reversal tracking and lock FSM next-state
  always_comb begin
    acc_n    = acc;
    q_n      = Q;
    rev_n    = rev_cnt;
    last_n   = last_dir;
    state_n  = state;
    sat_n    = sat;
    up_n     = 1'b0;
    dn_n     = 1'b0;
    vote     = '0;
    dir      = DIR_NONE;
    can_step = 1'b0;

    if (pd_valid && pd_up && !pd_dn) vote = AW'(1);
    else if (pd_valid && pd_dn && !pd_up) vote = AW'(-1);

    acc_sum = acc + vote;
    req_up  = (acc_sum == TH_P);
    req_dn  = (acc_sum == TH_N);

    if (en) begin
      acc_n = (req_up || req_dn) ? '0 : acc_sum;
      if (req_up || req_dn) begin
        dir      = req_up ? DIR_UP : DIR_DN;
        can_step = req_up ? (Q < 4'(Q_MAX)) : (Q > 4'(Q_MIN));
        if (can_step) begin
          q_n    = req_up ? Q + 4'd1 : Q - 4'd1;
          up_n   = req_up;
          dn_n   = req_dn;
          sat_n  = 1'b0;
          last_n = dir;
          if (last_dir != DIR_NONE) begin
            if (last_dir != dir) begin
              if (rev_cnt != RW'(LOCK_CNT)) rev_n = rev_cnt + RW'(1);
              if (state == ACQ && rev_n == RW'(LOCK_CNT)) state_n = LOCKED;
            end else begin
              rev_n   = '0;
              state_n = ACQ;
            end
          end
        end else begin
          // Request blocked at a bound: hold Q, flag saturation, drop lock
          sat_n = 1'b1;
          if (state == LOCKED) begin
            state_n = ACQ;
            rev_n   = '0;
          end
        end
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      Q        <= 4'(INIT_Q);
      rev_cnt  <= '0;
      last_dir <= DIR_NONE;
      state    <= ACQ;
      locked   <= 1'b0;
      sat      <= 1'b0;
      step_up  <= 1'b0;
      step_dn  <= 1'b0;
    end else begin
      acc      <= acc_n;
      Q        <= q_n;
      rev_cnt  <= rev_n;
      last_dir <= last_n;
      state    <= state_n;
      locked   <= (state_n == LOCKED);
      sat      <= sat_n;
      step_up  <= up_n;
      step_dn  <= dn_n;
    end
  end

endmodule
